// File: rtl/eth_xcvr_link_ctrl.sv
// eth_xcvr_link_ctrl: reset sequencer and link monitor for one transceiver lane.
// Brings the lane up, watches lock/BER status and retrains the RX side on loss.
module eth_xcvr_link_ctrl #(
  parameter int RESET_CYCLES       = 16,
  parameter int TIMEOUT_CYCLES     = 1000000,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int DROP_CYCLES        = 16,
  parameter int TIMER_WIDTH        = 24,
  parameter int RETRY_WIDTH        = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   restart,
  input  logic                   qpll_lock,
  input  logic                   tx_reset_done,
  input  logic                   rx_reset_done,
  input  logic                   rx_block_lock,
  input  logic                   rx_high_ber,
  output logic                   gt_reset_all,
  output logic                   gt_reset_rx_datapath,
  output logic                   link_up,
  output logic [2:0]             state,
  output logic [RETRY_WIDTH-1:0] retry_count,
  output logic [RETRY_WIDTH-1:0] link_drop_count
);

  typedef enum logic [2:0] {
    ST_RST_ALL   = 3'd0,
    ST_WAIT_PLL  = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_UP        = 3'd4,
    ST_RX_RST    = 3'd5
  } state_t;

  localparam logic [TIMER_WIDTH-1:0] T_ONE =
    TIMER_WIDTH'(1);
  localparam logic [RETRY_WIDTH-1:0] R_ONE =
    RETRY_WIDTH'(1);
  localparam logic [TIMER_WIDTH-1:0] RESET_LAST =
    TIMER_WIDTH'(RESET_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST =
    TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] LOCK_LAST =
    TIMER_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] DROP_LAST =
    TIMER_WIDTH'(DROP_CYCLES - 1);

  state_t                 state_q;
  state_t                 state_d;
  logic [TIMER_WIDTH-1:0] timer_q;
  logic [TIMER_WIDTH-1:0] stab_q;
  logic [TIMER_WIDTH-1:0] bad_q;
  logic                   timeout;
  logic                   bad_status;
  logic                   pll_lost;
  logic                   timer_clr;
  logic                   retry_inc;
  logic                   drop_inc;

  assign timeout    = (timer_q == TIMEOUT_LAST);
  assign bad_status = !rx_block_lock || rx_high_ber;
  assign pll_lost   = !qpll_lock &&
                      (state_q inside {ST_WAIT_DONE, ST_WAIT_LOCK,
                                       ST_UP, ST_RX_RST});
  // a restart while already in RST_ALL must still rewind the timer
  assign timer_clr  = restart || (state_d != state_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RST_ALL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    drop_inc  = 1'b0;
    if (restart || pll_lost) begin
      state_d = ST_RST_ALL;
    end else begin
      case (state_q)
        ST_RST_ALL: begin
          if (timer_q == RESET_LAST) begin
            state_d = ST_WAIT_PLL;
          end
        end
        ST_WAIT_PLL: begin
          if (qpll_lock) begin
            state_d = ST_WAIT_DONE;
          end else if (timeout) begin
            state_d   = ST_RST_ALL;
            retry_inc = 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (tx_reset_done && rx_reset_done) begin
            state_d = ST_WAIT_LOCK;
          end else if (timeout) begin
            state_d   = ST_RST_ALL;
            retry_inc = 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (rx_block_lock && stab_q == LOCK_LAST) begin
            state_d = ST_UP;
          end else if (timeout) begin
            state_d   = ST_RX_RST;
            retry_inc = 1'b1;
          end
        end
        ST_UP: begin
          if (bad_status && bad_q == DROP_LAST) begin
            state_d  = ST_RX_RST;
            drop_inc = 1'b1;
          end
        end
        ST_RX_RST: begin
          if (timer_q == RESET_LAST) begin
            state_d = ST_WAIT_DONE;
          end
        end
        default: state_d = ST_RST_ALL;
      endcase
    end
  end

  always_comb begin
    gt_reset_all         = (state_q == ST_RST_ALL);
    gt_reset_rx_datapath = (state_q == ST_RX_RST);
    link_up              = (state_q == ST_UP);
    state                = state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else if (timer_clr) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + T_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_q <= '0;
    end else if (state_q == ST_WAIT_LOCK &&
                 state_d == ST_WAIT_LOCK &&
                 rx_block_lock) begin
      stab_q <= stab_q + T_ONE;
    end else begin
      stab_q <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_q <= '0;
    end else if (state_q == ST_UP &&
                 state_d == ST_UP &&
                 bad_status) begin
      bad_q <= bad_q + T_ONE;
    end else begin
      bad_q <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_count     <= '0;
      link_drop_count <= '0;
    end else begin
      if (retry_inc && retry_count != '1) begin
        retry_count <= retry_count + R_ONE;
      end
      if (drop_inc && link_drop_count != '1) begin
        link_drop_count <= link_drop_count + R_ONE;
      end
    end
  end

endmodule

// File: tb/tb_eth_xcvr_link_ctrl.sv
// tb_eth_xcvr_link_ctrl: directed + random stimulus against a
// run-length behavioural model of the link sequencer.
module tb_eth_xcvr_link_ctrl;

  localparam int R = 4;
  localparam int T = 100;
  localparam int L = 8;
  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       restart = 1'b0;
  logic       qpll_lock = 1'b1;
  logic       tx_reset_done = 1'b1;
  logic       rx_reset_done = 1'b1;
  logic       rx_block_lock = 1'b1;
  logic       rx_high_ber = 1'b0;
  logic       gt_reset_all;
  logic       gt_reset_rx_datapath;
  logic       link_up;
  logic [2:0] state;
  logic [7:0] retry_count;
  logic [7:0] link_drop_count;

  int checks = 0;
  int errors = 0;

  eth_xcvr_link_ctrl #(
    .RESET_CYCLES(R),
    .TIMEOUT_CYCLES(T),
    .LOCK_STABLE_CYCLES(L),
    .DROP_CYCLES(D),
    .TIMER_WIDTH(24),
    .RETRY_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .restart(restart),
    .qpll_lock(qpll_lock),
    .tx_reset_done(tx_reset_done),
    .rx_reset_done(rx_reset_done),
    .rx_block_lock(rx_block_lock),
    .rx_high_ber(rx_high_ber),
    .gt_reset_all(gt_reset_all),
    .gt_reset_rx_datapath(gt_reset_rx_datapath),
    .link_up(link_up),
    .state(state),
    .retry_count(retry_count),
    .link_drop_count(link_drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: state name as int, age = cycles spent in the current state,
  // run lengths of good lock / bad status inside the state that needs them.
  int m_state, m_age, m_lock_run, m_bad_run, m_retry, m_drop;

  always @(posedge clk or posedge rst) begin
    int  nxt;
    bit  r_inc;
    bit  d_inc;
    bit  bad;
    if (rst) begin
      m_state = 0; m_age = 0; m_lock_run = 0;
      m_bad_run = 0; m_retry = 0; m_drop = 0;
    end else begin
      nxt = m_state;
      r_inc = 0;
      d_inc = 0;
      bad = !rx_block_lock || rx_high_ber;
      if (restart) nxt = 0;
      else if (!qpll_lock && m_state >= 2) nxt = 0;
      else if (m_state == 0) begin
        if (m_age + 1 == R) nxt = 1;
      end else if (m_state == 1) begin
        if (qpll_lock) nxt = 2;
        else if (m_age + 1 == T) begin nxt = 0; r_inc = 1; end
      end else if (m_state == 2) begin
        if (tx_reset_done && rx_reset_done) nxt = 3;
        else if (m_age + 1 == T) begin nxt = 0; r_inc = 1; end
      end else if (m_state == 3) begin
        if (rx_block_lock && m_lock_run + 1 == L) nxt = 4;
        else if (m_age + 1 == T) begin nxt = 5; r_inc = 1; end
      end else if (m_state == 4) begin
        if (bad && m_bad_run + 1 == D) begin nxt = 5; d_inc = 1; end
      end else begin
        if (m_age + 1 == R) nxt = 2;
      end
      if (r_inc && m_retry < 255) m_retry++;
      if (d_inc && m_drop < 255) m_drop++;
      if (nxt == m_state && !restart) begin
        m_age++;
        m_lock_run = (nxt == 3 && rx_block_lock) ? m_lock_run + 1 : 0;
        m_bad_run  = (nxt == 4 && bad) ? m_bad_run + 1 : 0;
      end else begin
        m_age = 0; m_lock_run = 0; m_bad_run = 0;
      end
      m_state = nxt;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("state", int'(state), m_state);
      chk("gt_reset_all", int'(gt_reset_all), int'(m_state == 0));
      chk("gt_reset_rx_dp", int'(gt_reset_rx_datapath), int'(m_state == 5));
      chk("link_up", int'(link_up), int'(m_state == 4));
      chk("retry_count", int'(retry_count), m_retry);
      chk("link_drop_count", int'(link_drop_count), m_drop);
      chk("resets_exclusive",
          int'(gt_reset_all && gt_reset_rx_datapath), 0);
    end
  end

  int seen_up;
  int p_lock, p_done, p_ber;

  initial begin
    // reset values
    tick(2);
    chk("rst_state", int'(state), 0);
    chk("rst_gt_reset_all", int'(gt_reset_all), 1);
    chk("rst_rx_dp", int'(gt_reset_rx_datapath), 0);
    chk("rst_link_up", int'(link_up), 0);
    chk("rst_retry", int'(retry_count), 0);
    chk("rst_drop", int'(link_drop_count), 0);
    rst = 1'b0;

    // bring-up with all inputs good: 4 + 1 + 1 + 8 = 14
    tick(3);
    chk("bringup_rst_hi_e3", int'(gt_reset_all), 1);
    tick(1);
    chk("bringup_rst_lo_e4", int'(gt_reset_all), 0);
    chk("bringup_wait_pll", int'(state), 1);
    tick(9);
    chk("bringup_not_up_e13", int'(link_up), 0);
    tick(1);
    chk("bringup_up_e14", int'(link_up), 1);
    chk("bringup_retry0", int'(retry_count), 0);
    chk("bringup_drop0", int'(link_drop_count), 0);

    // 2-cycle lock loss tolerated
    rx_block_lock = 1'b0;
    tick(2);
    rx_block_lock = 1'b1;
    tick(1);
    chk("drop2_still_up", int'(link_up), 1);

    // 3-cycle lock loss retrains
    rx_block_lock = 1'b0;
    tick(2);
    chk("drop3_up_before", int'(link_up), 1);
    tick(1);
    rx_block_lock = 1'b1;
    chk("drop3_rx_rst", int'(state), 5);
    chk("drop3_link_down", int'(link_up), 0);
    chk("drop3_count", int'(link_drop_count), 1);
    tick(3);
    chk("drop3_rx_dp_hi", int'(gt_reset_rx_datapath), 1);
    tick(1);
    chk("drop3_rx_dp_lo", int'(gt_reset_rx_datapath), 0);
    chk("drop3_wait_done", int'(state), 2);
    tick(9);
    chk("drop3_back_up", int'(link_up), 1);

    // PLL loss in UP: straight to RST_ALL, no count
    qpll_lock = 1'b0;
    tick(1);
    qpll_lock = 1'b1;
    chk("pll_loss_rst_all", int'(state), 0);
    chk("pll_loss_retry", int'(retry_count), 0);
    chk("pll_loss_drop", int'(link_drop_count), 1);
    tick(14);
    chk("pll_loss_back_up", int'(link_up), 1);

    // restart coinciding with a drop suppresses the drop count
    rx_block_lock = 1'b0;
    tick(2);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    rx_block_lock = 1'b1;
    chk("restart_drop_state", int'(state), 0);
    chk("restart_drop_count", int'(link_drop_count), 1);
    tick(14);
    chk("restart_back_up", int'(link_up), 1);

    // restart inside RST_ALL rewinds the timer
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    tick(2);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    tick(3);
    chk("restart_rewind_hold", int'(state), 0);
    tick(1);
    chk("restart_rewind_exit", int'(state), 1);

    // WAIT_LOCK with lock toggling every 5 cycles times out into RX_RST
    rx_block_lock = 1'b0;
    tick(2);
    chk("toggle_wait_lock", int'(state), 3);
    seen_up = 0;
    for (int i = 0; i < T; i++) begin
      rx_block_lock = ((i / 5) % 2) != 0;
      tick(1);
      if (link_up) seen_up++;
      if (i == T - 2) chk("toggle_still_lock", int'(state), 3);
    end
    chk("toggle_never_up", seen_up, 0);
    chk("toggle_rx_rst", int'(state), 5);
    chk("toggle_retry", int'(retry_count), 1);

    // async reset in the middle of WAIT_LOCK
    rx_block_lock = 1'b0;
    tick(5);
    chk("async_pre_lock", int'(state), 3);
    tick(2);
    #2 rst = 1'b1;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_gt_reset_all", int'(gt_reset_all), 1);
    chk("async_link_up", int'(link_up), 0);
    chk("async_retry", int'(retry_count), 0);
    chk("async_drop", int'(link_drop_count), 0);

    // qpll stuck low: 104-cycle retry loop, then saturation
    qpll_lock = 1'b0;
    rx_block_lock = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(R + T);
    chk("stuck_loop1_state", int'(state), 0);
    chk("stuck_loop1_retry", int'(retry_count), 1);
    tick(2 * (R + T));
    chk("stuck_312_retry", int'(retry_count), 3);
    tick(253 * (R + T));
    chk("stuck_sat_255", int'(retry_count), 255);
    tick(R + T);
    chk("stuck_sat_hold", int'(retry_count), 255);

    // randomized profiles
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int blk = 0; blk < 30; blk++) begin
      case ($urandom_range(0, 3))
        0: p_lock = 50;
        1: p_lock = 90;
        2: p_lock = 99;
        default: p_lock = 100;
      endcase
      case ($urandom_range(0, 2))
        0: p_done = 5;
        1: p_done = 50;
        default: p_done = 100;
      endcase
      p_ber = $urandom_range(0, 3);
      for (int c = 0; c < 200; c++) begin
        restart       = ($urandom_range(0, 499) == 0);
        qpll_lock     = (blk % 9 == 4) ? 1'b0 :
                        ($urandom_range(0, 299) != 0);
        tx_reset_done = ($urandom_range(0, 99) < p_done);
        rx_reset_done = ($urandom_range(0, 99) < p_done);
        rx_block_lock = ($urandom_range(0, 99) < p_lock);
        rx_high_ber   = ($urandom_range(0, 99) < p_ber);
        tick(1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
